// File: rtl/iterative_mdu.sv
// rtl/iterative_mdu.sv - iterative HI/LO multiply/divide unit; MDU_MACC_EN enables madd/maddu/msub/msubu
module iterative_mdu #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MUL_LAT = WIDTH / MUL_STEP;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // product accumulator, or {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;    // product / quotient sign
  logic                 rneg_q, rneg_d;  // remainder sign
  logic                 dz_q, dz_d;      // divide by zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
`ifdef MDU_MACC_EN
  logic                 macc_q, macc_d;
  logic                 msub_q, msub_d;
  logic                 is_acc_op, is_sub_op;
`endif

  logic                 is_mul_op, is_div_op, is_sgn_op, issue;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH+MUL_STEP-1:0] pp, upper;
  logic [2*WIDTH-1:0]   mul_next, mul_res, fix_mul;
  logic [WIDTH:0]       rem_sh, diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Decode the op field into operation classes
  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    is_sgn_op = 1'b0;
`ifdef MDU_MACC_EN
    is_acc_op = 1'b0;
    is_sub_op = 1'b0;
`endif
    case (op)
      4'd1: begin is_mul_op = 1'b1; is_sgn_op = 1'b1; end
      4'd2: is_mul_op = 1'b1;
      4'd3: begin is_div_op = 1'b1; is_sgn_op = 1'b1; end
      4'd4: is_div_op = 1'b1;
`ifdef MDU_MACC_EN
      4'd9:  begin is_mul_op = 1'b1; is_sgn_op = 1'b1; is_acc_op = 1'b1; end
      4'd10: begin is_mul_op = 1'b1; is_acc_op = 1'b1; end
      4'd11: begin is_mul_op = 1'b1; is_sgn_op = 1'b1; is_acc_op = 1'b1; is_sub_op = 1'b1; end
      4'd12: begin is_mul_op = 1'b1; is_acc_op = 1'b1; is_sub_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign issue = start & ~req & (is_mul_op | is_div_op) & (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE) | (start & ~req & (is_mul_op | is_div_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Operand magnitudes and datapath step / sign-fixup values
  always_comb begin
    a_neg = is_sgn_op & d1[WIDTH-1];
    b_neg = is_sgn_op & d2[WIDTH-1];
    a_mag = a_neg ? -d1 : d1;
    b_mag = b_neg ? -d2 : d2;

    // Multiply: low MUL_STEP bits of the accumulator hold the next multiplier slice
    pp       = {{MUL_STEP{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[MUL_STEP-1:0]};
    upper    = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
    mul_next = {upper, acc_q[WIDTH-1:MUL_STEP]};

    // Restoring divide: remainder in the upper half, dividend/quotient in the lower half
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd_q};
    q_bit    = ~diff[WIDTH];
    div_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

    mul_res = neg_q ? -acc_q : acc_q;
`ifdef MDU_MACC_EN
    if (macc_q) fix_mul = msub_q ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
    else        fix_mul = mul_res;
`else
    fix_mul = mul_res;
`endif
    quo_fix = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    rem_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: issue, iterate, fix up, abort and mthi/mtlo writes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MDU_MACC_EN
    macc_d   = macc_q;
    msub_d   = msub_q;
`endif
    if (req && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_d  = is_mul_op ? S_MUL : S_DIV;
            cnt_d    = is_mul_op ? MUL_CNT : DIV_CNT;
            acc_d    = {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
            opnd_d   = is_mul_op ? a_mag : b_mag;
            is_div_d = is_div_op;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = (d2 == '0);
`ifdef MDU_MACC_EN
            macc_d   = is_acc_op;
            msub_d   = is_sub_op;
`endif
          end else if (!start && !req) begin
            if (op == 4'd7) hi_d = d1;
            if (op == 4'd8) lo_d = d1;
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_FIX;
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          if (is_div_q) begin
            if (!dz_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end else begin
            {hi_d, lo_d} = fix_mul;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All unit state, FSM included, with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_MACC_EN
      macc_q   <= 1'b0;
      msub_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_MACC_EN
      macc_q   <= macc_d;
      msub_q   <= msub_d;
`endif
    end
  end

endmodule

// File: tb/tb_iterative_mdu.sv
// tb/tb_iterative_mdu.sv - self-checking bench for iterative_mdu (WIDTH=32, MUL_STEP=4; honours MDU_MACC_EN)
module tb_iterative_mdu;

  logic        clk = 1'b0;
  logic        reset, start, req, busy;
  logic [3:0]  op;
  logic [31:0] d1, d2, hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m;
  int          cyc;

  typedef struct {
    logic        st;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;
  vec_t tbl[$];
  vec_t v;

  iterative_mdu #(.WIDTH(32), .MUL_STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .req(req), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Architectural result of an op from the current {hi,lo}
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      4'd1: return 64'(sa * sb);
      4'd2: return up;
      4'd3: begin
        if (b == 0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return cur;
        return {a % b, a / b};
      end
      4'd7: return {a, cur[31:0]};
      4'd8: return {cur[63:32], a};
`ifdef MDU_MACC_EN
      4'd9:  return cur + 64'(sa * sb);
      4'd10: return cur + up;
      4'd11: return cur - 64'(sa * sb);
      4'd12: return cur - up;
`endif
      default: return cur;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return 10;
      4'd3, 4'd4: return 34;
`ifdef MDU_MACC_EN
      4'd9, 4'd10, 4'd11, 4'd12: return 10;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic issue_now(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; d1 = a; d2 = b; start = 1'b1;
  endtask

  // Counts busy cycles from the issue cycle; returns in the first busy=0 cycle
  task automatic wait_done(output int c);
    c = 0;
    #1;
    while (busy && c < 100) begin
      c++;
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    if (c == 0) begin
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    op = 4'd0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int c);
    @(negedge clk);
    issue_now(o, a, b);
    wait_done(c);
  endtask

  task automatic mtx(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; d1 = a; start = 1'b0;
    #1;
    check("mt_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    op = 4'd0;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req = 1'b0; op = 4'd0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_hilo", {hi, lo}, 64'd0);

    tbl.push_back('{1'b1, 4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 10});
    tbl.push_back('{1'b1, 4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       34});
    tbl.push_back('{1'b1, 4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    tbl.push_back('{1'b0, 4'd7, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFD, 0});
    tbl.push_back('{1'b1, 4'd3, 32'd5,        32'd0,        32'h1234,     32'hFFFFFFFD, 34});
    tbl.push_back('{1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34});
    tbl.push_back('{1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10});
    tbl.push_back('{1'b0, 4'd8, 32'hABCD,     32'd0,        32'hFFFFFFFE, 32'h0000ABCD, 0});
    tbl.push_back('{1'b1, 4'd13, 32'd1,       32'd1,        32'hFFFFFFFE, 32'h0000ABCD, 0});
    tbl.push_back('{1'b1, 4'd7, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h0000ABCD, 0});
    tbl.push_back('{1'b1, 4'd5, 32'd9,        32'd9,        32'hFFFFFFFE, 32'h0000ABCD, 0});
`ifndef MDU_MACC_EN
    tbl.push_back('{1'b1, 4'd9, 32'd3,        32'd3,        32'hFFFFFFFE, 32'h0000ABCD, 0});
    tbl.push_back('{1'b1, 4'd12, 32'd3,       32'd3,        32'hFFFFFFFE, 32'h0000ABCD, 0});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.st) begin
        run_op(v.op, v.a, v.b, cyc);
        check($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(v.cyc));
      end else begin
        mtx(v.op, v.a);
      end
      check($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, v.hi});
      check($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, v.lo});
    end
    m = {v.hi, v.lo};

    // Abort a multu on its 4th busy cycle
    @(negedge clk);
    issue_now(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); req = 1'b1;
    #1;
    check("abort_busy_before", {63'b0, busy}, 64'd1);
    @(negedge clk); req = 1'b0; op = 4'd0;
    #1;
    check("abort_busy_after", {63'b0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, m);
    // start together with req must not issue
    @(negedge clk);
    issue_now(4'd1, 32'd7, 32'd7); req = 1'b1;
    #1;
    check("req_block_busy", {63'b0, busy}, 64'd0);
    @(negedge clk); start = 1'b0; req = 1'b0; op = 4'd0;
    #1;
    check("req_block_busy2", {63'b0, busy}, 64'd0);
    check("req_block_hilo", {hi, lo}, m);

    // Back-to-back: div issued in the first busy=0 cycle after a mult
    run_op(4'd1, 32'd12345, 32'hFFFFFF00, cyc);
    m = model(4'd1, 32'd12345, 32'hFFFFFF00, m);
    check("b2b_mult_cycles", 64'(cyc), 64'd10);
    check("b2b_mult_hilo", {hi, lo}, m);
    issue_now(4'd4, 32'd1000003, 32'd97);
    wait_done(cyc);
    m = model(4'd4, 32'd1000003, 32'd97, m);
    check("b2b_div_cycles", 64'(cyc), 64'd34);
    check("b2b_div_hilo", {hi, lo}, m);

    // Reset during DIV
    @(negedge clk);
    issue_now(4'd3, 32'd999, 32'd10);
    repeat (5) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    check("div_reset_busy", {63'b0, busy}, 64'd0);
    check("div_reset_hilo", {hi, lo}, 64'd0);
    m = '0;

`ifdef MDU_MACC_EN
    mtx(4'd7, 32'd0);
    mtx(4'd8, 32'hFFFFFFFF);
    run_op(4'd10, 32'd1, 32'd1, cyc);
    check("maddu_cycles", 64'(cyc), 64'd10);
    check("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
    mtx(4'd7, 32'd0);
    mtx(4'd8, 32'd0);
    run_op(4'd11, 32'd2, 32'd3, cyc);
    check("msub_cycles", 64'(cyc), 64'd10);
    check("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    m = 64'hFFFFFFFF_FFFFFFFA;
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  o;
      logic [31:0] a, b;
      int          r;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) b = 32'd0;
      else if (r == 1) b = 32'($urandom_range(1, 15));
      else if (r == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (r == 3) a = 32'($urandom_range(0, 255));
      if (o == 4'd7 || o == 4'd8) begin
        mtx(o, a);
      end else begin
        run_op(o, a, b, cyc);
        check($sformatf("rnd%0d_op%0d_cycles", i, o), 64'(cyc), 64'(lat(o)));
      end
      m = model(o, a, b, m);
      check($sformatf("rnd%0d_op%0d_hilo", i, o), {hi, lo}, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
